// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared definitions for the data-memory responder.
// Holds the RV32I load/store func3 width codes and the responder FSM
// state encoding. Imported by dmem_lane_align and dmem_responder.
package dmem_pkg;

  // RV32I load/store width codes (func3 field)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_if -- load/store handshake bundle between the MEM stage (master)
// and the data-memory responder (slave).
//   req_valid/req_ready : request handshake
//   req_write           : 1 = store, 0 = load
//   req_addr            : byte address
//   req_wdata           : store data in the low-order bytes
//   req_func3           : RV32I width code
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata           : extended load result (0 for stores)
//   rsp_err             : access fault
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_func3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_func3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_func3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align -- combinational byte-lane steering for RV32I accesses.
// Optional feature macro: DMEM_MISALIGN_ERR_EN
//   defined   : misaligned or undefined func3 accesses flag err, write no
//               lanes and return zero load data
//   undefined : err is 0, addresses are force-aligned and undefined func3
//               codes behave as a full word
// Ports:
//   write      in   1 = store, 0 = load
//   func3      in   RV32I width code
//   addr_lo    in   byte offset within the word (addr[1:0])
//   wdata      in   store data, low-order justified
//   rword      in   word read from the array
//   wmask      out  per-byte write enable
//   wdata_lane out  store data replicated onto every candidate lane
//   rdata_ext  out  selected and sign/zero-extended load data
//   err        out  access fault
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        write,
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        err
);

  logic       is_byte;
  logic       is_half;
  logic       is_word;
  logic       sext;
  logic       bad_f3;
  logic [1:0] off;
  logic [31:0] shifted;

  always_comb begin
    is_byte = 1'b0;
    is_half = 1'b0;
    is_word = 1'b0;
    sext    = 1'b0;
    bad_f3  = 1'b0;
    case (func3)
      F3_B:    begin is_byte = 1'b1; sext = ~write; end
      F3_H:    begin is_half = 1'b1; sext = ~write; end
      F3_W:    is_word = 1'b1;
      F3_BU:   if (write) bad_f3 = 1'b1; else is_byte = 1'b1;
      F3_HU:   if (write) bad_f3 = 1'b1; else is_half = 1'b1;
      default: bad_f3 = 1'b1;
    endcase

`ifdef DMEM_MISALIGN_ERR_EN
    err = bad_f3 | (is_half & addr_lo[0]) | (is_word & (addr_lo != 2'b00));
    off = addr_lo;
`else
    // Unknown codes fall back to a full-word access; the offset is
    // truncated to the natural alignment of the access width.
    if (bad_f3) begin
      is_word = 1'b1;
    end
    err = 1'b0;
    if (is_word) begin
      off = 2'b00;
    end else if (is_half) begin
      off = {addr_lo[1], 1'b0};
    end else begin
      off = addr_lo;
    end
`endif

    case (1'b1)
      is_byte: wdata_lane = {4{wdata[7:0]}};
      is_half: wdata_lane = {2{wdata[15:0]}};
      default: wdata_lane = wdata;
    endcase

    shifted = rword >> {off, 3'b000};
    if (err) begin
      rdata_ext = 32'h0;
    end else if (is_byte) begin
      rdata_ext = {{24{sext & shifted[7]}}, shifted[7:0]};
    end else if (is_half) begin
      rdata_ext = {{16{sext & shifted[15]}}, shifted[15:0]};
    end else begin
      rdata_ext = rword;
    end
  end

  // A lane is written when it falls inside the access footprint.
  for (genvar gi = 0; gi < 4; gi++) begin : g_mask
    assign wmask[gi] = ~err & (is_word |
                               (is_half & (off[1] == gi[1])) |
                               (is_byte & (off == 2'(gi))));
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder -- memory-side end of the RV32I MEM-stage load/store port.
// Accepts one request at a time, waits WAIT_CYCLES extra cycles, commits the
// access against an internal word array and holds the response until it is
// taken.
// Optional feature macro: DMEM_MISALIGN_ERR_EN (misalignment faults).
// Parameters:
//   DEPTH_WORDS  words in the array (power of two, >= 4)
//   WAIT_CYCLES  extra access cycles before the response (0..15)
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-low reset
//   bus  dmem_if.slave request/response handshake bundle
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_t            state_reg;
  logic [3:0]        cnt_reg;
  logic              write_reg;
  logic [IDX_W+1:0]  addr_reg;
  logic [31:0]       wdata_reg;
  logic [2:0]        func3_reg;
  logic              req_ready_reg;
  logic              rsp_valid_reg;
  logic [31:0]       rsp_rdata_reg;
  logic              rsp_err_reg;

  logic [31:0]       mem [DEPTH_WORDS];
  logic [31:0]       rword_reg;

  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic              commit;
  logic [3:0]        wmask;
  logic [31:0]       wdata_lane;
  logic [31:0]       rdata_ext;
  logic              lane_err;

  logic unused_addr_hi;
  assign unused_addr_hi = &{1'b0, bus.req_addr[31:IDX_W+2]};

  assign commit = (state_reg == S_ACCESS) && (cnt_reg == 4'd0);
  assign wr_idx = addr_reg[IDX_W+1:2];
  // While idle, track the incoming address so the read register already
  // holds the target word when a zero-wait access commits one edge later.
  assign rd_idx = (state_reg == S_IDLE) ? bus.req_addr[IDX_W+1:2] : wr_idx;

  dmem_lane_align u_lane (
    .write      (write_reg),
    .func3      (func3_reg),
    .addr_lo    (addr_reg[1:0]),
    .wdata      (wdata_reg),
    .rword      (rword_reg),
    .wmask      (wmask),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext),
    .err        (lane_err)
  );

  // Storage: byte-enabled write, registered read, contents never reset.
  // Reset still blocks the commit so a store caught in ACCESS is dropped.
  always_ff @(posedge clk) begin
    if (rst && commit && write_reg) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) begin
          mem[wr_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
        end
      end
    end
    rword_reg <= mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= 4'd0;
      write_reg     <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= 32'h0;
      func3_reg     <= 3'b000;
      req_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= 32'h0;
      rsp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bus.req_valid && req_ready_reg) begin
            write_reg     <= bus.req_write;
            addr_reg      <= bus.req_addr[IDX_W+1:0];
            wdata_reg     <= bus.req_wdata;
            func3_reg     <= bus.req_func3;
            cnt_reg       <= 4'(WAIT_CYCLES);
            req_ready_reg <= 1'b0;
            state_reg     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else begin
            rsp_valid_reg <= 1'b1;
            rsp_rdata_reg <= write_reg ? 32'h0 : rdata_ext;
            rsp_err_reg   <= lane_err;
            state_reg     <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            req_ready_reg <= 1'b1;
            state_reg     <= S_IDLE;
          end
        end
        default: begin
          state_reg     <= S_IDLE;
          req_ready_reg <= 1'b1;
          rsp_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
`ifdef DMEM_MISALIGN_ERR_EN
  assign bus.rsp_err   = rsp_err_reg;
`else
  assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a byte-level reference memory
// predicts each response at issue time; a monitor pops and compares on
// every response handshake. A second zero-wait instance checks latency
// and address wrap.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DEPTH = 1024;
  localparam int W     = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  dmem_if bus ();
  dmem_if zbus ();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(zbus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem_b [DEPTH*4];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    string       name;
  } exp_t;
  exp_t q[$];

  bit bp_hold = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  // Reference: little-endian byte array, width/sign from func3.
  function automatic void model_do(input bit w, input logic [31:0] a, input logic [31:0] d,
                                   input logic [2:0] f, output logic [31:0] r, output logic e);
    int size;
    bit sgn;
    bit bad;
    int base;
    bad = 1'b0;
    if (w) begin
      case (f)
        3'd0: size = 1;
        3'd1: size = 2;
        3'd2: size = 4;
        default: begin size = 4; bad = 1'b1; end
      endcase
    end else begin
      case (f)
        3'd0, 3'd4: size = 1;
        3'd1, 3'd5: size = 2;
        3'd2: size = 4;
        default: begin size = 4; bad = 1'b1; end
      endcase
    end
    sgn = !w && (f == 3'd0 || f == 3'd1);
    r = 32'h0;
    e = 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
    if ((int'(a[1:0]) % size) != 0) bad = 1'b1;
    if (bad) begin
      e = 1'b1;
      return;
    end
`endif
    base = int'(a & (DEPTH*4 - 1));
    base = base - (base % size);
    if (w) begin
      for (int i = 0; i < size; i++) mem_b[base+i] = d[8*i +: 8];
    end else begin
      for (int i = 0; i < size; i++) r[8*i +: 8] = mem_b[base+i];
      if (sgn && r[8*size-1]) begin
        for (int i = 8*size; i < 32; i++) r[i] = 1'b1;
      end
    end
  endfunction

  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f, input bit push, input bit use_c,
                       input logic [31:0] cval, input string nm);
    exp_t e;
    logic [31:0] r;
    logic er;
    int n;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_func3 = f;
    bus.req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL %s accept: req_ready=%b want 1 within 200 cycles", nm, bus.req_ready);
      bus.req_valid = 1'b0;
      return;
    end
    e.acc = cyc + 1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    bus.req_func3 = 3'($urandom);
    if (push) begin
      model_do(w, a, d, f, r, er);
      e.rdata = use_c ? cval : r;
      e.err   = er;
      e.name  = nm;
      q.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d want 0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic zop(input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp, input string nm);
    int acc;
    int n;
    zbus.req_write = w;
    zbus.req_addr  = a;
    zbus.req_wdata = d;
    zbus.req_func3 = F3_W;
    zbus.req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!zbus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    acc = cyc + 1;
    @(posedge clk);
    #1;
    zbus.req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!zbus.rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " lat"}, 32'(cyc - acc), 32'd1);
    chk({nm, " rdata"}, zbus.rsp_rdata, exp);
    chk({nm, " err"}, {31'd0, zbus.rsp_err}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Response-ready driver: random unless back-pressure is being forced.
  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.rsp_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: latency on the first cycle a response shows, data on handshake.
  initial begin
    bit prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev = 1'b0;
      end else begin
        if (bus.rsp_valid && !prev) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected response: rdata=%h want no response", bus.rsp_rdata);
          end else begin
            chk({q[0].name, " lat"}, 32'(cyc - q[0].acc), 32'(W + 1));
          end
        end
        if (bus.rsp_valid && bus.rsp_ready && q.size() > 0) begin
          chk({q[0].name, " rdata"}, bus.rsp_rdata, q[0].rdata);
          chk({q[0].name, " err"}, {31'd0, bus.rsp_err}, {31'd0, q[0].err});
          void'(q.pop_front());
        end
        prev = bus.rsp_valid && !bus.rsp_ready;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] snap;
    int n;
    rst = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0; bus.req_func3 = 3'b0;
    zbus.req_valid = 1'b0; zbus.req_write = 1'b0; zbus.req_addr = 32'h0;
    zbus.req_wdata = 32'h0; zbus.req_func3 = 3'b0; zbus.rsp_ready = 1'b1;
    for (int i = 0; i < DEPTH*4; i++) mem_b[i] = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("reset rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("reset rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("reset rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    chk("reset z req_ready", {31'd0, zbus.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Give every word in the test window a known value.
    for (int i = 0; i < 32; i++) issue(1'b1, 32'(i*4), $urandom, F3_W, 1'b1, 1'b0, 32'h0, "init sw");

    issue(1'b1, 32'h10, 32'hDEADBEEF, F3_W,  1'b1, 1'b1, 32'h0,        "sw 10");
    issue(1'b0, 32'h10, 32'h0,        F3_W,  1'b1, 1'b1, 32'hDEADBEEF, "lw 10");
    issue(1'b1, 32'h11, 32'h0000007F, F3_B,  1'b1, 1'b1, 32'h0,        "sb 11");
    issue(1'b1, 32'h12, 32'h00008001, F3_H,  1'b1, 1'b1, 32'h0,        "sh 12");
    issue(1'b0, 32'h10, 32'h0,        F3_W,  1'b1, 1'b1, 32'h80017FEF, "lw 10 merged");
    issue(1'b0, 32'h13, 32'h0,        F3_B,  1'b1, 1'b1, 32'hFFFFFF80, "lb 13");
    issue(1'b0, 32'h13, 32'h0,        F3_BU, 1'b1, 1'b1, 32'h00000080, "lbu 13");
    issue(1'b0, 32'h12, 32'h0,        F3_HU, 1'b1, 1'b1, 32'h00008001, "lhu 12");
`ifdef DMEM_MISALIGN_ERR_EN
    issue(1'b0, 32'h12, 32'h0,        F3_W,  1'b1, 1'b1, 32'h00000000, "lw 12 misaligned");
    issue(1'b1, 32'h13, 32'h12345678, F3_W,  1'b1, 1'b1, 32'h0,        "sw 13 misaligned");
    issue(1'b0, 32'h10, 32'h0,        F3_W,  1'b1, 1'b1, 32'h80017FEF, "lw 10 after bad sw");
`else
    issue(1'b0, 32'h12, 32'h0,        F3_W,  1'b1, 1'b1, 32'h80017FEF, "lw 12 aligned down");
    issue(1'b1, 32'h13, 32'h12345678, F3_W,  1'b1, 1'b1, 32'h0,        "sw 13 aligned down");
    issue(1'b0, 32'h10, 32'h0,        F3_W,  1'b1, 1'b1, 32'h12345678, "lw 10 after sw 13");
`endif
    issue(1'b1, 32'h1000, 32'hCAFEF00D, F3_W, 1'b1, 1'b1, 32'h0,        "sw 1000");
    issue(1'b0, 32'h0,    32'h0,        F3_W, 1'b1, 1'b1, 32'hCAFEF00D, "lw 0 wrap");
    drain();

    // Back-pressure window with a stray request pulse.
    bp_hold = 1'b1;
    issue(1'b0, 32'h0, 32'h0, F3_W, 1'b1, 1'b1, 32'hCAFEF00D, "lw 0 bp");
    n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    snap = bus.rsp_rdata;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      bus.req_valid = (k == 1);
      bus.req_write = 1'b1;
      bus.req_addr  = 32'h0;
      bus.req_wdata = 32'h0;
      bus.req_func3 = F3_W;
      @(negedge clk);
      chk("bp rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("bp rsp_rdata", bus.rsp_rdata, snap);
      chk("bp req_ready", {31'd0, bus.req_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bp_hold = 1'b0;
    drain();
    issue(1'b0, 32'h0, 32'h0, F3_W, 1'b1, 1'b1, 32'hCAFEF00D, "lw 0 after bp");
    drain();

    // Reset while a store sits in ACCESS.
    issue(1'b1, 32'h20, 32'h00000055, F3_W, 1'b0, 1'b0, 32'h0, "sw 20 reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post-reset req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("post-reset rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    issue(1'b0, 32'h20, 32'h0, F3_W, 1'b1, 1'b0, 32'h0, "lw 20 prior");
    drain();

    // Random traffic over the initialised window, random upper address bits.
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 127));
      issue(1'($urandom), a, $urandom, 3'($urandom), 1'b1, 1'b0, 32'h0, "rand");
    end
    drain();

    // Zero-wait instance: one-edge latency and address wrap.
    zop(1'b1, 32'h1000, 32'hA5A55A5A, 32'h0,        "z sw 1000");
    zop(1'b0, 32'h0,    32'h0,        32'hA5A55A5A, "z lw 0 wrap");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
